// File: rtl/package_settings.sv
// Shared settings for the filter readout chain: data widths, the peak
// detector state type and the event record handed to the output register.
// Optional feature macro used by this slice: PEAK_WIDTH_EN.
package package_settings;

    localparam int SIZE_FILTER_DATA  = 16;
    localparam int SIZE_TEST_COUNTER = 16;
    localparam int SIZE_DELAY        = 7;

    typedef enum logic [1:0] {
        PD_IDLE,
        PD_ABOVE,
        PD_EMIT,
        PD_DEAD
    } pd_state_t;

    // The timestamp field is called ts because "time" is a reserved word.
    typedef struct packed {
        logic signed [SIZE_FILTER_DATA-1:0] amp;
        logic [SIZE_TEST_COUNTER-1:0]       ts;
        logic [SIZE_DELAY-1:0]              width;
    } pd_event_t;

    localparam logic [SIZE_DELAY-1:0]        DELAY_ONE = SIZE_DELAY'(1);
    localparam logic [SIZE_TEST_COUNTER-1:0] COUNT_ONE = SIZE_TEST_COUNTER'(1);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [SIZE_DELAY-1:0] sat_inc_delay(input logic [SIZE_DELAY-1:0] v);
        return (&v) ? v : v + DELAY_ONE;
    endfunction

endpackage

// File: rtl/pd_out_reg.sv
// One-entry valid/ready holding register for peak events. A new event that
// arrives while an unconsumed one is still held is dropped and counted.
module pd_out_reg
    import package_settings::*;
(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push_i,
    input  pd_event_t                    push_ev_i,
    input  logic                         ev_ready_i,
    output logic                         ev_valid_o,
    output pd_event_t                    ev_o,
    output logic [SIZE_TEST_COUNTER-1:0] lost_cnt_o
);

    logic                         valid_q, valid_d;
    pd_event_t                    ev_q, ev_d;
    logic [SIZE_TEST_COUNTER-1:0] lost_q, lost_d;

    // Consume on handshake; a push replaces the entry when it is free or
    // being consumed this cycle, otherwise it is lost (saturating count).
    always_comb begin
        valid_d = valid_q;
        ev_d    = ev_q;
        lost_d  = lost_q;
        if (valid_q && ev_ready_i) begin
            valid_d = 1'b0;
        end
        if (push_i) begin
            if (valid_q && !ev_ready_i) begin
                if (lost_q != '1) begin
                    lost_d = lost_q + COUNT_ONE;
                end
            end else begin
                valid_d = 1'b1;
                ev_d    = push_ev_i;
            end
        end
    end

    // State registers; reset clears the entry and the lost counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            ev_q    <= '0;
            lost_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ev_q    <= ev_d;
            lost_q  <= lost_d;
        end
    end

    assign ev_valid_o = valid_q;
    assign ev_o       = ev_q;
    assign lost_cnt_o = lost_q;

endmodule

// File: rtl/filter_peak_detector.sv
// Peak detector behind the shaping filter: finds pulses above a signed
// threshold, tracks peak amplitude and its timestamp, applies a dead time
// and hands one event per pulse to a valid/ready output register.
// Optional feature macro: PEAK_WIDTH_EN (pulse width counter on ev_width).
module filter_peak_detector
    import package_settings::*;
(
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               filt_valid,
    input  logic signed [SIZE_FILTER_DATA-1:0] filt_data,
    input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
    input  logic [SIZE_DELAY-1:0]              dead_time,
    output logic                               ev_valid,
    input  logic                               ev_ready,
    output logic signed [SIZE_FILTER_DATA-1:0] ev_amp,
    output logic [SIZE_TEST_COUNTER-1:0]       ev_time,
    output logic [SIZE_DELAY-1:0]              ev_width,
    output logic [SIZE_TEST_COUNTER-1:0]       lost_cnt
);

    pd_state_t                          state_q;
    logic [SIZE_TEST_COUNTER-1:0]       ts_q;
    logic signed [SIZE_FILTER_DATA-1:0] peak_q;
    logic [SIZE_TEST_COUNTER-1:0]       peak_time_q;
    logic [SIZE_DELAY-1:0]              dead_q;
    logic                               push_q;
    pd_event_t                          push_ev_q;
`ifdef PEAK_WIDTH_EN
    logic [SIZE_DELAY-1:0]              width_q;
`endif

    pd_event_t out_ev;
    logic      above;

    assign above = (filt_data > threshold);

    // Timestamp plus pulse FSM. The EMIT state registers a push strobe and
    // the event record, which the output register captures one clock later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= PD_IDLE;
            ts_q        <= '0;
            peak_q      <= '0;
            peak_time_q <= '0;
            dead_q      <= '0;
            push_q      <= 1'b0;
            push_ev_q   <= '0;
`ifdef PEAK_WIDTH_EN
            width_q     <= '0;
`endif
        end else begin
            push_q <= 1'b0;
            if (filt_valid) begin
                ts_q <= ts_q + COUNT_ONE;
            end
            case (state_q)
                PD_IDLE: begin
                    if (filt_valid && above) begin
                        state_q     <= PD_ABOVE;
                        peak_q      <= filt_data;
                        peak_time_q <= ts_q;
`ifdef PEAK_WIDTH_EN
                        width_q     <= DELAY_ONE;
`endif
                    end
                end
                PD_ABOVE: begin
                    if (filt_valid) begin
                        if (above) begin
                            if (filt_data > peak_q) begin
                                peak_q      <= filt_data;
                                peak_time_q <= ts_q;
                            end
`ifdef PEAK_WIDTH_EN
                            width_q <= sat_inc_delay(width_q);
`endif
                        end else begin
                            state_q <= PD_EMIT;
                        end
                    end
                end
                PD_EMIT: begin
                    push_q          <= 1'b1;
                    push_ev_q.amp   <= peak_q;
                    push_ev_q.ts    <= peak_time_q;
`ifdef PEAK_WIDTH_EN
                    push_ev_q.width <= width_q;
`else
                    push_ev_q.width <= '0;
`endif
                    dead_q          <= dead_time;
                    state_q         <= PD_DEAD;
                end
                PD_DEAD: begin
                    if (dead_q == '0) begin
                        state_q <= PD_IDLE;
                    end else if (filt_valid) begin
                        dead_q <= dead_q - DELAY_ONE;
                        if (dead_q == DELAY_ONE) begin
                            state_q <= PD_IDLE;
                        end
                    end
                end
                default: state_q <= PD_IDLE;
            endcase
        end
    end

    pd_out_reg u_out_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (push_q),
        .push_ev_i  (push_ev_q),
        .ev_ready_i (ev_ready),
        .ev_valid_o (ev_valid),
        .ev_o       (out_ev),
        .lost_cnt_o (lost_cnt)
    );

    // Without PEAK_WIDTH_EN the width field is constant zero.
    assign ev_amp   = out_ev.amp;
    assign ev_time  = out_ev.ts;
    assign ev_width = out_ev.width;

endmodule

// File: tb/tb_filter_peak_detector.sv
// Self-checking bench for filter_peak_detector: directed pulse scenarios
// followed by a randomized pulse stream compared with a sample-level model.
// Honours PEAK_WIDTH_EN for the expected ev_width values.
`timescale 1ns/1ps
module tb_filter_peak_detector;
    import package_settings::*;

    localparam int NR = 320;

    logic                               clk = 1'b0;
    logic                               reset_n;
    logic                               filt_valid;
    logic signed [SIZE_FILTER_DATA-1:0] filt_data;
    logic signed [SIZE_FILTER_DATA-1:0] threshold;
    logic [SIZE_DELAY-1:0]              dead_time;
    logic                               ev_valid;
    logic                               ev_ready;
    logic signed [SIZE_FILTER_DATA-1:0] ev_amp;
    logic [SIZE_TEST_COUNTER-1:0]       ev_time;
    logic [SIZE_DELAY-1:0]              ev_width;
    logic [SIZE_TEST_COUNTER-1:0]       lost_cnt;

    int checks = 0;
    int errors = 0;
    int tsExp  = 0;
    int evSeen = 0;

    int s   [NR];
    bit r   [NR];
    bit arr [NR+4];
    int aAmp[NR+4];
    int aTs [NR+4];
    int aW  [NR+4];

    int  thr, dead, tsBase, firstTs, allowedFrom, pk, pt, w, len;
    bit  inPulse, up;
    bit  mValid;
    int  mAmp, mTs, mW, mLost, idx;

    // Free-running 100 MHz sample clock.
    always #5 clk = ~clk;

    filter_peak_detector dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .filt_valid (filt_valid),
        .filt_data  (filt_data),
        .threshold  (threshold),
        .dead_time  (dead_time),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_amp     (ev_amp),
        .ev_time    (ev_time),
        .ev_width   (ev_width),
        .lost_cnt   (lost_cnt)
    );

    function automatic int expW(input int n);
`ifdef PEAK_WIDTH_EN
        return (n > 127) ? 127 : n;
`else
        return 0;
`endif
    endfunction

    task automatic applyStimulus(input logic v, input int d, input logic rdy);
        filt_valid = v;
        filt_data  = 16'(d);
        ev_ready   = rdy;
        @(posedge clk);
        #1;
        if (v && reset_n) tsExp++;
        if (ev_valid) evSeen++;
    endtask

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idleSamples(input int n, input logic rdy);
        for (int k = 0; k < n; k++) applyStimulus(1'b1, -20000, rdy);
    endtask

    task automatic checkEvent(input string tag, input int amp, input int ts, input int wd);
        checkOutput({tag, "_valid"}, ev_valid, 1);
        checkOutput({tag, "_amp"},   ev_amp,   amp);
        checkOutput({tag, "_time"},  ev_time,  ts & 16'hFFFF);
        checkOutput({tag, "_width"}, ev_width, wd);
    endtask

    initial begin
        // ---------------- reset state
        reset_n    = 1'b0;
        filt_valid = 1'b0;
        filt_data  = '0;
        threshold  = 16'sd100;
        dead_time  = 7'd4;
        ev_ready   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_valid", ev_valid, 0);
        checkOutput("rst_amp",   ev_amp,   0);
        checkOutput("rst_time",  ev_time,  0);
        checkOutput("rst_width", ev_width, 0);
        checkOutput("rst_lost",  lost_cnt, 0);
        reset_n = 1'b1;
        tsExp   = 0;

        // ---------------- test 1: ramp, latency, hold, handshake
        applyStimulus(1'b1, 0,   1'b0);
        applyStimulus(1'b1, 50,  1'b0);
        applyStimulus(1'b1, 150, 1'b0);
        applyStimulus(1'b1, 300, 1'b0);
        applyStimulus(1'b1, 200, 1'b0);
        applyStimulus(1'b1, 90,  1'b0);
        checkOutput("t1_lat0", ev_valid, 0);
        applyStimulus(1'b1, 0, 1'b0);
        checkOutput("t1_lat1", ev_valid, 0);
        applyStimulus(1'b1, 0, 1'b0);
        checkEvent("t1", 300, 3, expW(3));
        applyStimulus(1'b1, 0, 1'b0);
        checkEvent("t1_hold", 300, 3, expW(3));
        applyStimulus(1'b1, 0, 1'b1);
        checkOutput("t1_consumed", ev_valid, 0);

        // ---------------- test 2: equal peaks keep the first, invalid cycles hold
        idleSamples(8, 1'b0);
        firstTs = tsExp;
        applyStimulus(1'b1, 250, 1'b0);
        applyStimulus(1'b0, 999, 1'b0);
        applyStimulus(1'b0, 999, 1'b0);
        applyStimulus(1'b1, 250, 1'b0);
        applyStimulus(1'b1, 50,  1'b0);
        idleSamples(2, 1'b0);
        checkEvent("t2", 250, firstTs, expW(2));
        applyStimulus(1'b1, -20000, 1'b1);
        checkOutput("t2_consumed", ev_valid, 0);

        // ---------------- test 3: consumer stalled, later events lost
        idleSamples(8, 1'b0);
        firstTs = tsExp;
        applyStimulus(1'b1, 200, 1'b0);
        idleSamples(8, 1'b0);
        applyStimulus(1'b1, 300, 1'b0);
        idleSamples(8, 1'b0);
        applyStimulus(1'b1, 400, 1'b0);
        idleSamples(8, 1'b0);
        checkEvent("t3", 200, firstTs, expW(1));
        checkOutput("t3_lost", lost_cnt, 2);
        applyStimulus(1'b1, -20000, 1'b1);
        checkOutput("t3_consumed", ev_valid, 0);
        checkOutput("t3_lost_kept", lost_cnt, 2);

        // ---------------- test 4: re-crossing inside and beyond the dead window
        idleSamples(12, 1'b1);
        dead_time = 7'd10;
        evSeen = 0;
        applyStimulus(1'b1, 200, 1'b1);
        idleSamples(5, 1'b1);
        applyStimulus(1'b1, 200, 1'b1);
        idleSamples(30, 1'b1);
        checkOutput("t4_gap5_events", evSeen, 1);
        evSeen = 0;
        applyStimulus(1'b1, 200, 1'b1);
        idleSamples(12, 1'b1);
        applyStimulus(1'b1, 200, 1'b1);
        idleSamples(30, 1'b1);
        checkOutput("t4_gap12_events", evSeen, 2);

        // ---------------- test 5: reset in the middle of a pulse
        dead_time = 7'd4;
        idleSamples(8, 1'b0);
        applyStimulus(1'b1, 200, 1'b0);
        applyStimulus(1'b1, 300, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t5_rst_valid", ev_valid, 0);
        checkOutput("t5_rst_amp",   ev_amp,   0);
        checkOutput("t5_rst_time",  ev_time,  0);
        checkOutput("t5_rst_width", ev_width, 0);
        checkOutput("t5_rst_lost",  lost_cnt, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tsExp   = 0;
        idleSamples(2, 1'b0);
        applyStimulus(1'b1, 150, 1'b0);
        applyStimulus(1'b1, 50,  1'b0);
        idleSamples(2, 1'b0);
        checkEvent("t5", 150, 2, expW(1));
        checkOutput("t5_lost", lost_cnt, 0);
        applyStimulus(1'b1, -20000, 1'b1);

        // ---------------- test 6: pulse width, long (saturating) and short
        idleSamples(8, 1'b0);
        firstTs = tsExp;
        for (int k = 0; k < 200; k++) applyStimulus(1'b1, 500, 1'b0);
        applyStimulus(1'b1, 50, 1'b0);
        idleSamples(2, 1'b0);
        checkEvent("t6_long", 500, firstTs, expW(200));
        applyStimulus(1'b1, -20000, 1'b1);
        idleSamples(8, 1'b0);
        firstTs = tsExp;
        applyStimulus(1'b1, 120, 1'b0);
        applyStimulus(1'b1, 130, 1'b0);
        applyStimulus(1'b1, 110, 1'b0);
        applyStimulus(1'b1, 100, 1'b0);
        idleSamples(2, 1'b0);
        checkEvent("t6_short", 130, firstTs + 1, expW(3));
        applyStimulus(1'b1, -20000, 1'b1);

        // ---------------- random pulse stream against the reference model
        idleSamples(12, 1'b1);
        thr  = int'($urandom_range(0, 600)) - 300;
        dead = int'($urandom_range(0, 6));
        threshold = 16'(thr);
        dead_time = 7'(dead);
        idleSamples(4, 1'b1);
        idx = 0;
        while (idx < NR - 20) begin
            len = int'($urandom_range(1, 8));
            up  = 1'($urandom_range(0, 1));
            for (int k = 0; k < len && idx < NR - 20; k++) begin
                s[idx] = up ? thr + 1 + int'($urandom_range(0, 400))
                            : thr - int'($urandom_range(0, 400));
                idx++;
            end
        end
        for (int i = NR - 20; i < NR; i++) s[i] = thr - int'($urandom_range(0, 400));
        for (int i = 0; i < NR; i++) r[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < NR + 4; i++) arr[i] = 1'b0;

        // Events from the sample list: a pulse is a run of samples above the
        // threshold; after it ends the next 1+max(dead,1) samples are blind.
        tsBase      = tsExp;
        allowedFrom = 0;
        inPulse     = 1'b0;
        pk = 0; pt = 0; w = 0;
        for (int i = 0; i < NR; i++) begin
            if (!inPulse) begin
                if (i >= allowedFrom && s[i] > thr) begin
                    inPulse = 1'b1; pk = s[i]; pt = i; w = 1;
                end
            end else if (s[i] > thr) begin
                if (s[i] > pk) begin pk = s[i]; pt = i; end
                w = w + 1;
            end else begin
                inPulse     = 1'b0;
                arr[i+2]    = 1'b1;
                aAmp[i+2]   = pk;
                aTs[i+2]    = tsBase + pt;
                aW[i+2]     = expW(w);
                allowedFrom = i + 2 + ((dead > 1) ? dead : 1);
            end
        end

        mValid = 1'b0;
        mLost  = 0;
        mAmp = 0; mTs = 0; mW = 0;
        for (int c = 0; c < NR; c++) begin
            applyStimulus(1'b1, s[c], r[c]);
            if (mValid && r[c]) mValid = 1'b0;
            if (arr[c]) begin
                if (mValid) begin
                    if (mLost != 65535) mLost++;
                end else begin
                    mValid = 1'b1;
                    mAmp = aAmp[c]; mTs = aTs[c]; mW = aW[c];
                end
            end
            checkOutput("rnd_valid", ev_valid, mValid);
            checkOutput("rnd_lost",  lost_cnt, mLost);
            if (mValid) begin
                checkOutput("rnd_amp",   ev_amp,   mAmp);
                checkOutput("rnd_time",  ev_time,  mTs & 16'hFFFF);
                checkOutput("rnd_width", ev_width, mW);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
